// File: rtl/dmem_responder.sv
// dmem_responder: handshaked load/store data memory with a programmable response latency.
// Optional macro DMEM_MISALIGN_CHECK_EN: fault misaligned half/word accesses instead of masking the low address bits.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          LAST_INT = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [3:0]  LAST_CNT = LAST_INT[3:0];
    localparam logic [31:0] DEPTH_U  = DEPTH_WORDS[31:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Effective request: live inputs in IDLE (needed when LATENCY is 0), captured copy afterwards.
    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_size;
    logic        a_uns;

    logic [1:0]       lane;
    logic [1:0]       eff_lane;
    logic             range_err;
    logic             size_err;
    logic             align_err;
    logic             fault;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_rep;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_val;
    logic             do_access;
    logic             mem_we;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        a_we    = we_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_size  = size_q;
        a_uns   = uns_q;
        if (state_q == S_IDLE) begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_size  = req_size;
            a_uns   = req_unsigned;
        end
    end

    always_comb begin
        lane      = a_addr[1:0];
        range_err = ({2'b00, a_addr[31:2]} >= DEPTH_U);
        size_err  = (a_size == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
        eff_lane  = lane;
        align_err = ((a_size == 2'b01) && lane[0]) ||
                    ((a_size == 2'b10) && (lane != 2'b00));
`else
        align_err = 1'b0;
        case (a_size)
            2'b01:   eff_lane = {lane[1], 1'b0};
            2'b10:   eff_lane = 2'b00;
            default: eff_lane = lane;
        endcase
`endif
        fault = range_err || size_err || align_err;

        // Replicating the store data lets the byte enables alone pick the target lanes.
        case (a_size)
            2'b00: begin
                byte_en   = 4'b0001 << eff_lane;
                wdata_rep = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                byte_en   = 4'b0011 << eff_lane;
                wdata_rep = {2{a_wdata[15:0]}};
            end
            2'b10: begin
                byte_en   = 4'b1111;
                wdata_rep = a_wdata;
            end
            default: begin
                byte_en   = 4'b0000;
                wdata_rep = a_wdata;
            end
        endcase
    end

    always_comb begin
        idx      = a_addr[IDX_W+1:2];
        rd_word  = mem[idx];
        byte_sel = rd_word[{eff_lane, 3'b000} +: 8];
        half_sel = rd_word[{eff_lane[1], 4'b0000} +: 16];
        case (a_size)
            2'b00:   load_val = a_uns ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'b01:   load_val = a_uns ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: load_val = rd_word;
        endcase
    end

    // The array access happens on exactly the edge that moves the FSM into RESP.
    always_comb begin
        do_access = 1'b0;
        if (!rst) begin
            if ((state_q == S_IDLE) && req_valid && (LATENCY == 0)) begin
                do_access = 1'b1;
            end else if ((state_q == S_WAIT) && (cnt_q == LAST_CNT)) begin
                do_access = 1'b1;
            end
        end
        mem_we = do_access && a_we && !fault;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    cnt_d   = 4'd0;
                    state_d = (LATENCY > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_access) begin
            err_d   = fault;
            rdata_d = (fault || a_we) ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: two responders (LATENCY 2 and LATENCY 0) share one request/response stream.
module tb_dmem_responder;
    localparam int LAT_A = 2;
    localparam int LAT_B = 0;

`ifdef DMEM_MISALIGN_CHECK_EN
    localparam logic [31:0] MIS_W_RD  = 32'h0;
    localparam logic        MIS_W_ERR = 1'b1;
    localparam logic [31:0] MIS_H_RD  = 32'h0;
    localparam logic        MIS_H_ERR = 1'b1;
`else
    localparam logic [31:0] MIS_W_RD  = 32'hDEADBEEF;
    localparam logic        MIS_W_ERR = 1'b0;
    localparam logic [31:0] MIS_H_RD  = 32'h00005678;
    localparam logic        MIS_H_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [31:0] rsp_rdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_A)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on both responders; response checked on arrival and on every held cycle.
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input int hold,
                       input logic [31:0] exp_a, input logic exp_err_a,
                       input logic [31:0] exp_b, input logic exp_err_b);
        int lat_a;
        int lat_b;
        lat_a = -1;
        lat_b = -1;
        chk({tag, "_rdy_a"}, {31'h0, req_ready_a}, 32'd1);
        chk({tag, "_rdy_b"}, {31'h0, req_ready_b}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        @(posedge clk); #1;
        req_valid    = 1'b0;
        req_we       = ~we;
        req_addr     = 32'hFFFF_FFFF;
        req_wdata    = ~wdata;
        req_size     = 2'b11;
        req_unsigned = ~uns;
        for (int n = 0; n < 40; n++) begin
            if (rsp_valid_b && (lat_b < 0)) lat_b = n;
            if (rsp_valid_a) begin
                lat_a = n;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_lat_a"}, lat_a, LAT_A);
        chk({tag, "_lat_b"}, lat_b, LAT_B);
        for (int h = 0; h <= hold; h++) begin
            chk({tag, "_vld_a"}, {31'h0, rsp_valid_a}, 32'd1);
            chk({tag, "_rd_a"}, rsp_rdata_a, exp_a);
            chk({tag, "_err_a"}, {31'h0, rsp_err_a}, {31'h0, exp_err_a});
            chk({tag, "_rd_b"}, rsp_rdata_b, exp_b);
            chk({tag, "_err_b"}, {31'h0, rsp_err_b}, {31'h0, exp_err_b});
            chk({tag, "_busy_a"}, {31'h0, req_ready_a}, 32'd0);
            if (h < hold) begin
                @(posedge clk); #1;
            end
        end
        $display("txn %s we=%0d addr=%h size=%0d uns=%0d rdata_a=%h err_a=%0d rdata_b=%h err_b=%0d",
                 tag, we, addr, size, uns, rsp_rdata_a, rsp_err_a, rsp_rdata_b, rsp_err_b);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_done_vld_a"}, {31'h0, rsp_valid_a}, 32'd0);
        chk({tag, "_done_rdy_a"}, {31'h0, req_ready_a}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy_a", {31'h0, req_ready_a}, 32'd0);
        chk("rst_vld_a", {31'h0, rsp_valid_a}, 32'd0);
        chk("rst_rd_a", rsp_rdata_a, 32'h0);
        chk("rst_err_a", {31'h0, rsp_err_a}, 32'd0);
        chk("rst_vld_b", {31'h0, rsp_valid_b}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Word store/load round trip
        txn("st_w0",    1'b1, 32'h00, 32'h11223344, 2'b10, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        txn("st_w10",   1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        txn("ld_w10",   1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);

        // Byte lanes with sign/zero extension
        txn("st_w20",   1'b1, 32'h20, 32'h00000000, 2'b10, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        txn("st_b21",   1'b1, 32'h21, 32'h12345680, 2'b00, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        txn("ld_b21s",  1'b0, 32'h21, 32'h0, 2'b00, 1'b0, 0, 32'hFFFFFF80, 1'b0, 32'hFFFFFF80, 1'b0);
        txn("ld_b21u",  1'b0, 32'h21, 32'h0, 2'b00, 1'b1, 0, 32'h00000080, 1'b0, 32'h00000080, 1'b0);
        txn("ld_w20",   1'b0, 32'h20, 32'h0, 2'b10, 1'b1, 0, 32'h00008000, 1'b0, 32'h00008000, 1'b0);
        txn("ld_b13s",  1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 0, 32'hFFFFFFDE, 1'b0, 32'hFFFFFFDE, 1'b0);

        // Halfword lanes
        txn("st_w30",   1'b1, 32'h30, 32'h12345678, 2'b10, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        txn("st_h32",   1'b1, 32'h32, 32'hAAAABEEF, 2'b01, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        txn("ld_w30",   1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 0, 32'hBEEF5678, 1'b0, 32'hBEEF5678, 1'b0);
        txn("ld_h32s",  1'b0, 32'h32, 32'h0, 2'b01, 1'b0, 0, 32'hFFFFBEEF, 1'b0, 32'hFFFFBEEF, 1'b0);
        txn("ld_h30u",  1'b0, 32'h30, 32'h0, 2'b01, 1'b1, 0, 32'h00005678, 1'b0, 32'h00005678, 1'b0);

        // Range and reserved-size faults; index 0x100 must not alias onto word 0
        txn("ld_oor",   1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 0, 32'h0, 1'b1, 32'h0, 1'b1);
        txn("st_oor",   1'b1, 32'h400, 32'hCAFEF00D, 2'b10, 1'b0, 0, 32'h0, 1'b1, 32'h0, 1'b1);
        txn("ld_w0",    1'b0, 32'h00, 32'h0, 2'b10, 1'b0, 0, 32'h11223344, 1'b0, 32'h11223344, 1'b0);
        txn("ld_rsvd",  1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 0, 32'h0, 1'b1, 32'h0, 1'b1);
        txn("st_rsvd",  1'b1, 32'h10, 32'h0, 2'b11, 1'b0, 0, 32'h0, 1'b1, 32'h0, 1'b1);
        txn("ld_w10b",  1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);

        // Response held for 5 cycles with rsp_ready low
        txn("hold5",    1'b0, 32'h30, 32'h0, 2'b10, 1'b0, 5, 32'hBEEF5678, 1'b0, 32'hBEEF5678, 1'b0);

        // Misaligned accesses
        txn("mis_w13",  1'b0, 32'h13, 32'h0, 2'b10, 1'b0, 0, MIS_W_RD, MIS_W_ERR, MIS_W_RD, MIS_W_ERR);
        txn("mis_h31",  1'b0, 32'h31, 32'h0, 2'b01, 1'b1, 0, MIS_H_RD, MIS_H_ERR, MIS_H_RD, MIS_H_ERR);

        // Reset while the LATENCY-2 responder waits on a store; LATENCY-0 has already committed it
        txn("st_w50",   1'b1, 32'h50, 32'h0BADF00D, 2'b10, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h50;
        req_wdata = 32'hA5A5A5A5;
        req_size  = 2'b10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("mid_wait_vld_a", {31'h0, rsp_valid_a}, 32'd0);
        chk("mid_resp_vld_b", {31'h0, rsp_valid_b}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_rdy_a", {31'h0, req_ready_a}, 32'd0);
        chk("mid_rst_vld_a", {31'h0, rsp_valid_a}, 32'd0);
        chk("mid_rst_rd_a", rsp_rdata_a, 32'h0);
        chk("mid_rst_err_a", {31'h0, rsp_err_a}, 32'd0);
        chk("mid_rst_vld_b", {31'h0, rsp_valid_b}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_rdy_a", {31'h0, req_ready_a}, 32'd1);
        chk("post_rst_rdy_b", {31'h0, req_ready_b}, 32'd1);
        txn("ld_w50",   1'b0, 32'h50, 32'h0, 2'b10, 1'b0, 0, 32'h0BADF00D, 1'b0, 32'hA5A5A5A5, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Responder side of the core's load/store port: a handshaked data memory that accepts one load/store request from the datapath, waits a programmable latency, then returns read data and an error flag. It supports byte, halfword and word accesses with little-endian lane steering and sign/zero extension. It lets the multi-cycle datapath stall on memory instead of assuming a combinational read.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the backing array; valid word index range is 0..DEPTH_WORDS-1.
LATENCY, 2, wait cycles between accept and response, range 0..15.

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified for byte/half
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load: 1 = zero-extend, 0 = sign-extend
rsp_valid  output  1  response present
rsp_ready  input  1  requester consumes response
rsp_rdata  output  32  load result (0 for stores and errors)
rsp_err  output  1  access fault for this response

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, latency counter 0. req_ready is 0 while rst is high. Array contents are not reset.
- FSM states: IDLE, WAIT, RESP. At most one request is outstanding.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at edge T: capture we/addr/wdata/size/unsigned and clear the counter.
  - Next state is WAIT if LATENCY > 0, otherwise RESP.
- WAIT:
  - req_ready = 0. The counter increments each cycle.
  - When counter == LATENCY-1, go to RESP.
  - rsp_valid first rises in cycle T+1+LATENCY.
- Entering RESP (single edge):
  - Perform the array access: store commits, or load data is extracted.
  - Register rsp_rdata and rsp_err.
- RESP:
  - rsp_valid = 1. rsp_rdata and rsp_err hold stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid.
  - req_ready rises the following cycle. There is no same-cycle re-accept.
- Addressing:
  - Word index = addr[31:2]; lane = addr[1:0], little-endian.
  - Byte store writes lane addr[1:0] with wdata[7:0].
  - Half store writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word store writes all lanes.
- Load extraction:
  - Selected byte or half goes to rdata LSBs.
  - Upper bits are sign- or zero-extended per req_unsigned. Word loads ignore req_unsigned.
- Errors (rsp_err = 1, no array write, rsp_rdata = 0):
  - Word index >= DEPTH_WORDS.
  - req_size == 11.
  - Misaligned access (only when the macro below is defined).
- Stores always return rsp_rdata = 0.
- Reset mid-operation: a request in WAIT is abandoned with no write. A response in RESP is dropped and rsp_valid goes to 0 on the reset edge.
- Inputs are don't-care outside the accept cycle. Captured values govern the whole transaction.

Optional Feature:
DMEM_MISALIGN_CHECK_EN
- Defined: halfword with addr[0]=1, or word with addr[1:0]!=00, responds rsp_err=1, with no write and rdata 0.
- Undefined: offending low address bits are forced to zero (half masks addr[0]; word masks addr[1:0]), the access proceeds, and rsp_err reports only range and reserved-size faults.

Test Plan:
- LATENCY=2: word store addr 0x10 data 0xDEADBEEF accepted at cycle T, then word load addr 0x10 -> rsp_valid at T+3 for each transaction; load returns 0xDEADBEEF, rsp_err 0.
- Store byte 0x80 at 0x21, then load byte signed 0x21 -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word 0x20 -> 0x00008000 (with 0x20 pre-zeroed).
- Store half 0xBEEF at 0x32, then load word 0x30 -> lanes 3:2 = 0xBEEF, lanes 1:0 unchanged; load half signed 0x32 -> 0xFFFFBEEF.
- DEPTH_WORDS=256: load addr 0x400 -> rsp_err 1, rdata 0. Store 0x400 -> rsp_err 1, and array words 0..255 are unchanged.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err are stable and req_ready stays 0. Assert rst while in WAIT on a store -> store not committed, all outputs 0, req_ready 1 the cycle after rst falls.
- Misaligned word load at 0x13:
  - Macro defined -> rsp_err 1, rdata 0.
  - Macro undefined -> returns the word at 0x10, rsp_err 0.
  - Also covers LATENCY=0: response in cycle T+1.
